// File: rtl/tap_window_sreg_pkg.sv
// Shared sizing helpers and tap slice indexing for the tap window delay line.
// Pure compile-time functions; no logic, no latency, no flow control.
package tap_window_sreg_pkg;

    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A stride of 1 still needs a 1-bit counter so the wrap compare stays legal.
    function automatic int stride_width(input int stride);
        return (stride > 1) ? $clog2(stride) : 1;
    endfunction

    function automatic int tap_lsb(input int k, input int c, input int channels, input int dw);
        return (k * channels + c) * dw;
    endfunction

endpackage

// File: rtl/tap_sreg_lane.sv
// One lane of the delay line: tap0 takes din on en, older taps shift up by one.
// One-cycle load latency; holds when en is low, clr zeroes all taps.
module tap_sreg_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 7
) (
    input  logic                        clk,
    input  logic                        en,
    input  logic                        clr,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DEPTH*DATA_WIDTH-1:0] taps
);

    logic [DEPTH*DATA_WIDTH-1:0] sreg;

    always_ff @(posedge clk) begin
        if (clr) begin
            sreg <= '0;
        end else if (en) begin
            sreg <= {sreg[(DEPTH-1)*DATA_WIDTH-1:0], din};
        end
    end

    assign taps = sreg;

endmodule

// File: rtl/tap_window_sreg.sv
// Multi-lane tap delay line exposing the last DEPTH samples as a window, with fill and stride control.
// Sample on tap0 one cycle after accept; a pending unconsumed window stalls input (in_ready low).
module tap_window_sreg
    import tap_window_sreg_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 7,
    parameter int  CHANNELS   = 1,
    parameter int  STRIDE     = 1,
    localparam int FW         = fill_width(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]       din,
    output logic [DEPTH*CHANNELS*DATA_WIDTH-1:0] taps,
    output logic                                 win_valid,
    input  logic                                 win_ready,
    output logic [FW-1:0]                        fill_level
);

    localparam int            SW          = stride_width(STRIDE);
    localparam logic [FW-1:0] FILL_FULL   = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_LAST   = FW'(DEPTH - 1);
    localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);

    logic          accept;
    logic          full;
    logic          filling;
    logic          wrap;
    logic          emit;
    logic          clr;
    logic [SW-1:0] stride_cnt;
    logic [DEPTH*DATA_WIDTH-1:0] lane_taps [CHANNELS];

    assign in_ready = !rst && !flush && (!win_valid || win_ready);
    assign accept   = in_valid && in_ready;
    assign full     = (fill_level == FILL_FULL);
    assign filling  = accept && (fill_level == FILL_LAST);
    assign wrap     = accept && full && (stride_cnt == STRIDE_LAST);
    assign emit     = filling || wrap;
    assign clr      = rst || flush;

    always_ff @(posedge clk) begin
        if (clr) begin
            fill_level <= '0;
            stride_cnt <= '0;
            win_valid  <= 1'b0;
        end else begin
            if (accept && !full) begin
                fill_level <= fill_level + FW'(1);
            end
            if (emit) begin
                stride_cnt <= '0;
            end else if (accept && full) begin
                stride_cnt <= stride_cnt + SW'(1);
            end
            // A consumed window is replaced in the same cycle if a new one is emitted.
            if (emit) begin
                win_valid <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        tap_sreg_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_lane (
            .clk (clk),
            .en  (accept),
            .clr (clr),
            .din (din[c*DATA_WIDTH +: DATA_WIDTH]),
            .taps(lane_taps[c])
        );
    end

    // Interleave lanes so all channels of one tap are adjacent.
    always_comb begin
        taps = '0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                taps[tap_lsb(k, c, CHANNELS, DATA_WIDTH) +: DATA_WIDTH] =
                    lane_taps[c][k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
